conv_engine: RTL and testbench
==============================

CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 SHALL have parameter IMG_N, default 6: image is IMG_N x IMG_N pixels, delivered one row per cycle.
REQ-002 SHALL have parameter K, default 2: kernel is K x K, with 2 <= K <= IMG_N.
REQ-003 SHALL have parameter NUM_KER, default 6: kernel count, with 1 <= NUM_KER <= IMG_N.
REQ-004 SHALL have parameter PIX_W, default 3: unsigned pixel and kernel-element width.
REQ-005 SHALL have port clk, input, 1: the single clock; reset is synchronous and active-low.
REQ-006 SHALL have port rst_n, input, 1: synchronous active-low reset, sampled on rising clk.
REQ-007 SHALL have port in_valid, input, 1: input frame beat qualifier.
REQ-008 SHALL have port in_row, input, IMG_N*PIX_W: one image row; bits [PIX_W-1:0] = column 0.
REQ-009 SHALL have port in_kernel, input, K*K*PIX_W: one kernel, row-major; bits [PIX_W-1:0] = element (0,0).
REQ-010 SHALL have port out_ready, input, 1: sink ready; present only under CONV_BP_EN.
REQ-011 SHALL have port out_valid, output, 1: out_data qualifier.
REQ-012 SHALL have port out_data, output, OUT_W: one convolution result, where OUT_W = clog2(K*K*(2^PIX_W-1)^2 + 1), which is 8 at the defaults.

Function
REQ-013 SHALL use FSM states IDLE, LOAD, CALC and OUT; a frame starts only in IDLE on in_valid=1, and is ignored in any other state.
REQ-014 SHALL hold in_valid high for exactly IMG_N consecutive cycles per frame; cycle r captures in_row as row r.
REQ-015 SHALL capture in_kernel as kernel r on frame cycle r, for r < NUM_KER; in_kernel SHALL be ignored on cycles r >= NUM_KER.
REQ-016 SHALL discard the frame and return to IDLE on the next edge if in_valid drops before IMG_N beats, producing no output.
REQ-017 SHALL compute each result as the unsigned valid-mode (no padding, stride 1) sum of K*K products, full precision, with no truncation.
REQ-018 SHALL emit NUM_KER*(IMG_N-K+1)^2 results per frame (150 at the defaults), ordered kernel-major, then output row, then output column.
REQ-019 SHALL make the first out_valid=1 appear exactly 2 cycles after the last in_valid=1 cycle; LOAD to CALC takes 1 cycle for the pipeline fill.
REQ-020 SHALL keep out_valid high on consecutive cycles, one result per accepted beat, with no gaps unless out_ready=0.
REQ-021 SHALL drive out_data to 0 whenever out_valid=0.
REQ-022 SHALL never assert out_valid in a cycle where in_valid=1.
REQ-023 SHALL go OUT to IDLE on the cycle after the last result is accepted; the next frame may start on the following cycle.

Reset
REQ-024 SHALL, when rst_n=0 at a clk edge, set state to IDLE, out_valid=0, out_data=0, and clear all counters.
REQ-025 SHALL let reset asserted mid-LOAD or mid-OUT abort the frame; the next edge after deassertion SHALL show out_valid=0 and out_data=0.
REQ-026 SHALL not require the image or kernel storage to be cleared by reset.

Configuration
REQ-027 SHALL, with CONV_BP_EN defined, provide port out_ready; a beat is accepted when out_valid && out_ready, and out_data SHALL be held stable while out_valid && !out_ready.
REQ-028 SHALL, without CONV_BP_EN, omit port out_ready, treat the sink as always ready, and emit the results back-to-back.

Structure
REQ-029 SHALL place the state enum, the OUT_W function and output-count constants in shared package conv_pkg.
REQ-030 SHALL use one sub-module, conv_mac: a K*K multiply-add tree with one register stage, instantiated once.

Verification
REQ-031 SHALL check: all pixels=1, all kernel elements=1 (defaults) -> 150 beats, each 4, first beat 2 cycles after in_valid falls.
REQ-032 SHALL check: all pixels=7, all kernel elements=7 -> 150 beats, each 196 (maximum, no overflow).
REQ-033 SHALL check: identity kernel ((0,0)=1, others 0), pixel(r,c)=(r+c)%8 -> beats 0..24 equal pixel(r,c) for r,c in 0..4.
REQ-034 SHALL check: in_valid dropped after 3 beats -> out_valid never rises; the following full frame produces 150 correct beats.
REQ-035 SHALL check: CONV_BP_EN with out_ready=0 for 3 cycles at beat 10 -> out_data frozen at beat 10, 150 total beats, none lost or duplicated.
REQ-036 SHALL check: rst_n=0 for 1 cycle at beat 50 -> out_valid=0 and out_data=0 next cycle, FSM in IDLE, new frame correct.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

    // Width that holds K*K full-scale products without wrap.
    function automatic int calc_out_w(input int k, input int pix_w);
        int m;
        m = (1 << pix_w) - 1;
        return $clog2(k * k * m * m + 1);
    endfunction

    function automatic int num_results(input int img_n, input int k, input int num_ker);
        return num_ker * (img_n - k + 1) * (img_n - k + 1);
    endfunction

    localparam int DEF_OUT_W       = calc_out_w(2, 3);
    localparam int DEF_NUM_RESULTS = num_results(6, 2, 6);

endpackage

// File: rtl/conv_mac.sv
// K*K multiply-add tree with a single enabled output register.
module conv_mac
    import conv_pkg::*;
#(
    parameter int K     = 2,
    parameter int PIX_W = 3,
    parameter int OUT_W = 8
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic [K*K*PIX_W-1:0]   pix,
    input  logic [K*K*PIX_W-1:0]   ker,
    output logic [OUT_W-1:0]       sum_q
);

    logic [OUT_W-1:0] sum_d;

    always_comb begin
        sum_d = '0;
        for (int e = 0; e < K*K; e++)
            sum_d = sum_d + OUT_W'(pix[e*PIX_W +: PIX_W]) * OUT_W'(ker[e*PIX_W +: PIX_W]);
    end

    // Holding the register when disabled keeps out_data stable under a stall.
    always_ff @(posedge clk) begin
        if (en) sum_q <= sum_d;
    end

endmodule

// File: rtl/conv_engine.sv
// Valid-mode 2D convolution of one IMG_N x IMG_N frame against NUM_KER kernels.
// Define CONV_BP_EN to add the out_ready backpressure port.
module conv_engine
    import conv_pkg::*;
#(
    parameter int IMG_N   = 6,
    parameter int K       = 2,
    parameter int NUM_KER = 6,
    parameter int PIX_W   = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    input  logic [IMG_N*PIX_W-1:0]             in_row,
    input  logic [K*K*PIX_W-1:0]               in_kernel,
`ifdef CONV_BP_EN
    input  logic                               out_ready,
`endif
    output logic                               out_valid,
    output logic [calc_out_w(K, PIX_W)-1:0]    out_data
);

    localparam int OUT_W = calc_out_w(K, PIX_W);
    localparam int OUT_N = IMG_N - K + 1;
    localparam int TOTAL = num_results(IMG_N, K, NUM_KER);
    localparam int ROW_W = $clog2(IMG_N);
    localparam int KW    = (NUM_KER > 1) ? $clog2(NUM_KER) : 1;
    localparam int CW    = $clog2(TOTAL + 1);

    state_t                                state;
    logic [ROW_W-1:0]                      beat, wr_row;
    logic [KW-1:0]                         ker_i, nxt_ker;
    logic [ROW_W-1:0]                      row_i, col_i, nxt_row, nxt_col;
    logic [CW-1:0]                         issued;
    logic [IMG_N-1:0][IMG_N*PIX_W-1:0]     img;
    logic [NUM_KER-1:0][K*K*PIX_W-1:0]     kers;
    logic [K*K*PIX_W-1:0]                  win;
    logic [OUT_W-1:0]                      mac_q;
    logic                                  sink_rdy, accept, last, mac_en;

`ifdef CONV_BP_EN
    assign sink_rdy = out_ready;
`else
    assign sink_rdy = 1'b1;
`endif

    assign accept = out_valid & sink_rdy;
    assign last   = (issued == CW'(TOTAL));
    assign mac_en = (state == CALC) || (state == OUT && accept && !last);
    assign wr_row = (state == IDLE) ? '0 : beat;

    always_ff @(posedge clk) begin
        if (in_valid && (state == IDLE || state == LOAD)) begin
            img[wr_row] <= in_row;
            if (int'(wr_row) < NUM_KER) kers[KW'(wr_row)] <= in_kernel;
        end
    end

    always_comb begin
        win = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                win[(i*K+j)*PIX_W +: PIX_W] = img[row_i + ROW_W'(i)][(int'(col_i)+j)*PIX_W +: PIX_W];
    end

    // Issue order is kernel-major, then output row, then output column.
    always_comb begin
        nxt_col = col_i + 1'b1;
        nxt_row = row_i;
        nxt_ker = ker_i;
        if (int'(col_i) == OUT_N - 1) begin
            nxt_col = '0;
            nxt_row = row_i + 1'b1;
            if (int'(row_i) == OUT_N - 1) begin
                nxt_row = '0;
                nxt_ker = ker_i + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            beat      <= '0;
            ker_i     <= '0;
            row_i     <= '0;
            col_i     <= '0;
            issued    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ker_i  <= '0;
                    row_i  <= '0;
                    col_i  <= '0;
                    issued <= '0;
                    if (in_valid) begin
                        beat  <= ROW_W'(1);
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!in_valid) begin
                        beat  <= '0;
                        state <= IDLE;
                    end else if (int'(beat) == IMG_N - 1) begin
                        state <= CALC;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                CALC: begin
                    ker_i     <= nxt_ker;
                    row_i     <= nxt_row;
                    col_i     <= nxt_col;
                    issued    <= CW'(1);
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (accept) begin
                        if (last) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            ker_i  <= nxt_ker;
                            row_i  <= nxt_row;
                            col_i  <= nxt_col;
                            issued <= issued + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    conv_mac #(.K(K), .PIX_W(PIX_W), .OUT_W(OUT_W)) u_mac (
        .clk   (clk),
        .en    (mac_en),
        .pix   (win),
        .ker   (kers[ker_i]),
        .sum_q (mac_q)
    );

    assign out_data = out_valid ? mac_q : '0;

endmodule

// File: tb/tb_conv_engine.sv
// Scoreboard bench for conv_engine: directed frames, monitor pops expected beats.
module tb_conv_engine;
    import conv_pkg::*;

    localparam int IMG_N   = 6;
    localparam int K       = 2;
    localparam int NUM_KER = 6;
    localparam int PIX_W   = 3;
    localparam int OUT_N   = 5;
    localparam int TOTAL   = 150;
    localparam int OUT_W   = 8;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic [IMG_N*PIX_W-1:0]   in_row = '0;
    logic [K*K*PIX_W-1:0]     in_kernel = '0;
    logic                     out_ready = 1'b1;
    logic                     out_valid;
    logic [OUT_W-1:0]         out_data;

    conv_engine #(.IMG_N(IMG_N), .K(K), .NUM_KER(NUM_KER), .PIX_W(PIX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_row    (in_row),
        .in_kernel (in_kernel),
`ifdef CONV_BP_EN
        .out_ready (out_ready),
`endif
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int   checks = 0, errors = 0;
    int   q[$];
    int   beats = 0, rises = 0, rise_cyc = 0, last_in_cyc = 0;
    logic prev_v = 1'b0;
    int   img_t[IMG_N][IMG_N];
    int   ker_t[NUM_KER][K*K];
    int   b0, r0;

    // Monitor: pops on every accepted beat, checks hold and idle-zero otherwise.
    always @(negedge clk) begin
        int exp_v;
        if (in_valid) begin
            last_in_cyc = cyc;
            checks++;
            if (out_valid) begin
                errors++;
                $display("FAIL overlap: out_valid=1 while in_valid=1 at cycle %0d", cyc);
            end
        end
        if (out_valid && !prev_v) begin
            rises++;
            rise_cyc = cyc;
        end
        prev_v = out_valid;
        checks++;
        if (!out_valid) begin
            if (out_data !== '0) begin
                errors++;
                $display("FAIL idle_zero: out_data=%0d required 0", out_data);
            end
        end else if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: out_data=%0d with empty scoreboard", out_data);
        end else if (out_ready) begin
            exp_v = q.pop_front();
            if (out_data !== OUT_W'(exp_v)) begin
                errors++;
                $display("FAIL beat %0d: out_data=%0d required %0d", beats, out_data, exp_v);
            end
            beats++;
        end else if (out_data !== OUT_W'(q[0])) begin
            errors++;
            $display("FAIL stall_hold: out_data=%0d required %0d", out_data, q[0]);
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp_v);
        end
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < IMG_N; r++)
            for (int c = 0; c < IMG_N; c++) img_t[r][c] = v;
        for (int k = 0; k < NUM_KER; k++)
            for (int e = 0; e < K*K; e++) ker_t[k][e] = v;
    endtask

    task automatic push_const(input int v);
        for (int n = 0; n < TOTAL; n++) q.push_back(v);
    endtask

    // pixel(r,c)=(r+c)%8; kernel k has a single 1 at element k%4.
    task automatic fill_ident();
        for (int r = 0; r < IMG_N; r++)
            for (int c = 0; c < IMG_N; c++) img_t[r][c] = (r + c) % 8;
        for (int k = 0; k < NUM_KER; k++)
            for (int e = 0; e < K*K; e++) ker_t[k][e] = (e == k % 4) ? 1 : 0;
    endtask

    task automatic push_ident();
        for (int k = 0; k < NUM_KER; k++)
            for (int r = 0; r < OUT_N; r++)
                for (int c = 0; c < OUT_N; c++)
                    q.push_back(((r + (k / 2) % 2) + (c + k % 2)) % 8);
    endtask

    task automatic send(input int nb);
        for (int r = 0; r < nb; r++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            for (int c = 0; c < IMG_N; c++) in_row[c*PIX_W +: PIX_W] = PIX_W'(img_t[r][c]);
            for (int e = 0; e < K*K; e++) begin
                if (r < NUM_KER) in_kernel[e*PIX_W +: PIX_W] = PIX_W'(ker_t[r][e]);
                else             in_kernel[e*PIX_W +: PIX_W] = PIX_W'($urandom);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_start(input int nb);
        b0 = beats;
        r0 = rises;
        send(nb);
    endtask

    task automatic run_finish(input int n, input string name);
        int g = 0;
        while (beats - b0 < n && g < 2000) begin
            @(posedge clk);
            g++;
        end
        repeat (20) @(posedge clk);
        chk({name, "_count"}, beats - b0, n);
        chk({name, "_left"}, q.size(), 0);
        if (n > 0) begin
            chk({name, "_latency"}, rise_cyc - last_in_cyc, 2);
            chk({name, "_bursts"}, rises - r0, 1);
        end else begin
            chk({name, "_no_rise"}, rises - r0, 0);
        end
    endtask

    task automatic wait_beats(input int n);
        int g = 0;
        while (beats - b0 < n && g < 2000) begin
            @(posedge clk);
            g++;
        end
        chk("reach_beat", (beats - b0 >= n) ? 1 : 0, 1);
    endtask

    initial begin
        int bx;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);

        fill_const(1); push_const(4);
        run_start(IMG_N); run_finish(TOTAL, "ones");

        fill_const(7); push_const(196);
        run_start(IMG_N); run_finish(TOTAL, "sevens");

        fill_ident(); push_ident();
        run_start(IMG_N); run_finish(TOTAL, "ident");

        fill_const(3);
        run_start(3); run_finish(0, "abort");
        fill_ident(); push_ident();
        run_start(IMG_N); run_finish(TOTAL, "after_abort");

`ifdef CONV_BP_EN
        fill_ident(); push_ident();
        run_start(IMG_N);
        wait_beats(10);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        run_finish(TOTAL, "stall");
`endif

        fill_ident(); push_ident();
        run_start(IMG_N);
        wait_beats(50);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        q.delete();
        @(negedge clk);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_data", int'(out_data), 0);
        bx = beats;
        repeat (10) @(posedge clk);
        chk("midrst_quiet", beats - bx, 0);

        fill_const(2); push_const(16);
        run_start(IMG_N); run_finish(TOTAL, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
